sr_pq_r: RTL
============

// Module: sr_pq_r
// PURPOSE
//  Parametrised shift-register priority queue: DEPTH chained stages, min-key at head.
//  Supports enqueue, dequeue and single-cycle replace (simultaneous enq+deq).
//  Adds per-stage valid bits, occupancy count, full/empty flags and error reporting.
//  Drop-in successor for the simplified enq/deq-only PQ in the HWPQ study harness.
// PARAMETERS
//  DEPTH    8                     number of stages (>=2)
//  CNT_W    $clog2(DEPTH+1)       width of count output (derived; do not override)
// PORTS
//  clk      in   1       clock, all state updates on posedge
//  rst      in   1       synchronous, active-high reset
//  enq      in   1       enqueue kvi this cycle
//  deq      in   1       dequeue head this cycle; enq&&deq = replace
//  kvi      in   kv_t    key-value to insert
//  kvo      out  kv_t    head entry (stage 1 register); KV_EMPTY when empty
//  kvo_vld  out  1       head entry valid (= !empty)
//  count    out  CNT_W   number of valid entries, 0..DEPTH
//  full     out  1       count==DEPTH
//  empty    out  1       count==0
//  err      out  1       1-cycle pulse: illegal op (deq on empty; enq on full w/o SR_PQ_OVF_EN)
// BEHAVIOUR
//  - Reset: all stages vld=0, kv=KV_EMPTY; count=0, empty=1, full=0, err=0, kvo_vld=0.
//  - rst has priority over any op in the same cycle; an op in progress is simply lost.
//  - Latency: op sampled at posedge; kvo/count/flags reflect it from the next cycle. kvo is
//    registered (no comb path from kvi/enq/deq to outputs except none).
//  - Compare per stage i: lt[i] = !vld[i] || (kvi.key < kv[i].key); virtual stage DEPTH+1
//    has lt=1, virtual stage 0 has lt=0. Strict < => equal keys kept FIFO (new after old).
//  - Enqueue (enq&&!deq, !full): stage i <= kvi if !lt[i-1]&&lt[i]; <= stage i-1 if
//    lt[i-1]&&lt[i]; else hold. count+1.
//  - Dequeue (deq&&!enq, !empty): stage i <= stage i+1 (last stage <= invalid). count-1.
//  - Replace (enq&&deq, !empty): head removed (kvo before edge is the removed item), kvi
//    inserted: stage i <= stage i+1 if !lt[i+1]; else kvi if (i==1 || !lt[i]); else hold.
//    count unchanged. Legal when full.
//  - Replace on empty: treated as plain enqueue; err=0.
//  - Deq on empty: no state change, err=1 for one cycle.
//  - Enq on full (no deq): see CONFIGURATION.
//  - Idle (!enq&&!deq): hold all state, err=0.
// CONFIGURATION
//  SR_PQ_OVF_EN defined: adds outputs ovf_vld (1, pulse) and ovf_kv (kv_t, reg, reset
//    KV_EMPTY). Enq on full: if lt[DEPTH] kvi inserted as normal enqueue, old stage DEPTH
//    ejected on ovf_kv; else kvi itself ejected on ovf_kv. ovf_vld=1 next cycle, count stays
//    DEPTH, err=0.
//  SR_PQ_OVF_EN undefined: ports absent; enq on full ignored (no state change), err=1.
// STRUCTURE
//  - pq_pkg: kv_t {key,value}, KEY_BITS, VAL_BITS, KV_EMPTY; add typedef pq_op_t
//    (OP_NONE, OP_ENQ, OP_DEQ, OP_REPL) decoded once at top level.
//  - Sub-module sr_pq_r_stage: holds kv+vld, computes lt, applies enq/deq/replace rule from
//    op, kvi, prev/next neighbour kv+vld+lt; stage index as parameter STAGE.
//  - Top: generate loop of DEPTH stages, op decode, count/flag/err regs, optional ovf regs.
// TESTING
//  - Reset then enq keys 5,3,9,1 -> kvo.key=1, count=4; deq x4 yields keys 1,3,5,9, empty=1.
//  - Enq key 4 val A, then key 4 val B, deq x2 -> A then B (FIFO on ties).
//  - Queue {2,6,8}; replace with key 7 -> removed 2, contents {6,7,8}, count=3;
//    replace with key 1 -> removed 6, head=1.
//  - Deq on empty -> err pulse 1 cycle, count=0, kvo=KV_EMPTY; replace on empty key 3 ->
//    count=1, head=3, err=0.
//  - Fill DEPTH=8 with keys 10..80, enq key 5: without macro -> err, contents unchanged;
//    with SR_PQ_OVF_EN -> ovf_kv.key=80, head=5; then enq 90 -> ovf_kv.key=90.
//  - Assert rst mid-sequence with enq high -> next cycle count=0, empty=1, kvo_vld=0.

Source files
------------

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared key/value types, empty marker and op encoding for the shift-register PQ
package pq_pkg;

    localparam int KEY_BITS = 8;
    localparam int VAL_BITS = 8;

    typedef struct packed {
        logic [KEY_BITS-1:0] key;
        logic [VAL_BITS-1:0] value;
    } kv_t;

    // Invalid stages always carry this pattern so the head output needs no extra muxing
    localparam kv_t KV_EMPTY = '{key: {KEY_BITS{1'b1}}, value: {VAL_BITS{1'b0}}};

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ENQ  = 2'd1,
        OP_DEQ  = 2'd2,
        OP_REPL = 2'd3
    } pq_op_t;

    // Strict ordering: equal keys never overtake, which keeps ties in arrival order
    function automatic logic key_before(input kv_t a, input kv_t b);
        return a.key < b.key;
    endfunction

endpackage

// File: rtl/sr_pq_r_stage.sv
// rtl/sr_pq_r_stage.sv - one queue stage: holds kv+vld, decides its next value from neighbours
module sr_pq_r_stage
    import pq_pkg::*;
#(
    parameter int STAGE = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  pq_op_t op,
    input  kv_t    kvi,
    input  kv_t    prev_kv,
    input  logic   prev_vld,
    input  logic   prev_lt,
    input  kv_t    next_kv,
    input  logic   next_vld,
    input  logic   next_lt,
    output kv_t    kv,
    output logic   vld,
    output logic   lt
);

    localparam logic IS_HEAD = (STAGE == 1);

    kv_t  kv_d;
    logic vld_d;

    // An empty stage always compares as "new item goes here or earlier"
    assign lt = !vld || key_before(kvi, kv);

    // Next-value selection for enqueue, dequeue and replace
    always_comb begin
        kv_d  = kv;
        vld_d = vld;
        unique case (op)
            OP_ENQ: begin
                if (prev_lt && lt) begin
                    // Item ahead of us is displaced backwards by the insertion
                    kv_d  = prev_kv;
                    vld_d = prev_vld;
                end else if (!prev_lt && lt) begin
                    // Insertion point: first stage whose key is larger than kvi
                    kv_d  = kvi;
                    vld_d = 1'b1;
                end
            end
            OP_DEQ: begin
                kv_d  = next_kv;
                vld_d = next_vld;
            end
            OP_REPL: begin
                if (!next_lt) begin
                    // Next item still sorts before kvi, so it moves up into the freed slot
                    kv_d  = next_kv;
                    vld_d = next_vld;
                end else if (IS_HEAD || !lt) begin
                    kv_d  = kvi;
                    vld_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Stage register with synchronous reset to the empty marker
    always_ff @(posedge clk) begin
        if (rst) begin
            kv  <= KV_EMPTY;
            vld <= 1'b0;
        end else begin
            kv  <= kv_d;
            vld <= vld_d;
        end
    end

endmodule

// File: rtl/sr_pq_r.sv
// rtl/sr_pq_r.sv - DEPTH-stage shift-register priority queue, min key at head; optional SR_PQ_OVF_EN overflow eject
module sr_pq_r
    import pq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  kv_t              kvi,
    output kv_t              kvo,
    output logic             kvo_vld,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
`ifdef SR_PQ_OVF_EN
    output logic             ovf_vld,
    output kv_t              ovf_kv,
`endif
    output logic             err
);

    // Index 0 and DEPTH+1 are virtual neighbours that bound the chain
    kv_t    kv_a  [0:DEPTH+1];
    logic   vld_a [0:DEPTH+1];
    logic   lt_a  [0:DEPTH+1];
    pq_op_t op;
    logic   op_err;
`ifdef SR_PQ_OVF_EN
    logic   ovf_hit;
`endif

    assign kv_a[0]        = KV_EMPTY;
    assign vld_a[0]       = 1'b0;
    assign lt_a[0]        = 1'b0;
    assign kv_a[DEPTH+1]  = KV_EMPTY;
    assign vld_a[DEPTH+1] = 1'b0;
    assign lt_a[DEPTH+1]  = 1'b1;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign kvo     = kv_a[1];
    assign kvo_vld = vld_a[1];

    // Decode enq/deq into a single operation for all stages, flag illegal requests
    always_comb begin
        op     = OP_NONE;
        op_err = 1'b0;
`ifdef SR_PQ_OVF_EN
        ovf_hit = 1'b0;
`endif
        if (enq && deq && !empty) begin
            op = OP_REPL;
        end else if (enq) begin
            // Replace on an empty queue lands here and behaves as a plain enqueue
            if (!full) begin
                op = OP_ENQ;
            end else begin
`ifdef SR_PQ_OVF_EN
                // Normal enqueue pushes the tail out; if kvi sorts last nothing moves
                op      = OP_ENQ;
                ovf_hit = 1'b1;
`else
                op_err  = 1'b1;
`endif
            end
        end else if (deq) begin
            if (!empty) begin
                op = OP_DEQ;
            end else begin
                op_err = 1'b1;
            end
        end
    end

    for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
        sr_pq_r_stage #(
            .STAGE(i)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .op      (op),
            .kvi     (kvi),
            .prev_kv (kv_a[i-1]),
            .prev_vld(vld_a[i-1]),
            .prev_lt (lt_a[i-1]),
            .next_kv (kv_a[i+1]),
            .next_vld(vld_a[i+1]),
            .next_lt (lt_a[i+1]),
            .kv      (kv_a[i]),
            .vld     (vld_a[i]),
            .lt      (lt_a[i])
        );
    end

    // Occupancy counter and single-cycle error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= op_err;
            unique case (op)
                OP_ENQ:  if (!full) count <= count + CNT_W'(1);
                OP_DEQ:  count <= count - CNT_W'(1);
                default: begin
                end
            endcase
        end
    end

`ifdef SR_PQ_OVF_EN
    // Capture whichever entry falls off the end on an enqueue into a full queue
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_vld <= 1'b0;
            ovf_kv  <= KV_EMPTY;
        end else begin
            ovf_vld <= ovf_hit;
            if (ovf_hit) begin
                ovf_kv <= lt_a[DEPTH] ? kv_a[DEPTH] : kvi;
            end
        end
    end
`endif

endmodule
